seq_mult_nbit: RTL and testbench
================================

SEQ_MULT_NBIT -- requirements
Module: seq_mult_nbit

Interface
REQ-001 Parameter: N, default 32, operand width in bits.
REQ-002 The block SHALL expose the following ports, one per line:
  clk      input   1    single system clock; all state changes on rising edge
  rst_n    input   1    reset, asynchronous, active-low
  start    input   1    request to begin a multiply; sampled on clk
  a        input   N    multiplicand, unsigned
  b        input   N    multiplier, unsigned
  busy     output  1    high while a multiply is in progress
  done     output  1    one-cycle pulse when product is valid
  product  output  2N   unsigned result a*b
REQ-003 The block SHALL use one clock (clk), with reset asynchronous and active-low (rst_n).

Function
REQ-004 The block SHALL compute product = a*b, exact, 2N bits, with no overflow possible.
REQ-005 Algorithm SHALL be shift-and-add: one multiplier bit per cycle, LSB first.
  - Accumulator is {carry, hi[N-1:0], lo[N-1:0]}.
  - lo is preloaded with b.
  - hi is cleared at start.
REQ-006 Each RUN cycle SHALL work as follows.
  - If lo[0]=1, hi_next_raw = hi + mcand, computed as N-bit add with carry-out.
  - Otherwise, hi_next_raw = hi and carry = 0.
  - The block then shifts {carry, hi_next_raw, lo} right by 1.
REQ-007 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-008 IDLE behaviour:
  - If start=1, the block captures a into mcand and b into lo, clears hi, loads cnt=N, and moves to RUN.
  - Otherwise it stays in IDLE.
REQ-009 RUN behaviour:
  - The block performs one step per cycle and decrements cnt.
  - When cnt reaches 1 at the step edge, it moves to DONE.
REQ-010 DONE behaviour:
  - done=1 for exactly one cycle.
  - The next state is IDLE, or RUN if start=1 in that cycle (back-to-back accepted, operands captured as in IDLE).
REQ-011 Latency: with start sampled at edge t, done SHALL be high in the cycle after edge t+N, and product SHALL be valid in that same cycle.
REQ-012 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-013 start SHALL be ignored in RUN; operands are not re-captured and the in-flight result is unaffected.
REQ-014 product SHALL be driven from the accumulator register.
  - It holds the last completed result in IDLE/DONE until the next accepted start.
  - Intermediate values during RUN are don't-care to consumers.
REQ-015 The a and b inputs SHALL be sampled only on the accepting edge; later changes have no effect.
REQ-016 cnt width SHALL be clog2(N)+1 bits, so that a value of N is representable.

Reset
REQ-017 While rst_n=0:
  - state=IDLE
  - busy=0, done=0, product=0
  - cnt=0, mcand=0
REQ-018 Reset asserted mid-RUN SHALL abort the operation immediately, with no done pulse.
REQ-019 After reset deassertion, the block SHALL accept start on the first rising edge.

Structure
REQ-020 A shared package SHALL hold:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - the default width constant (32)
REQ-021 The N-bit adder SHALL be instantiated as one sub-module, full_adder_nbit #(N) (A, B, Cin=0, Sum, Cout).
  - Cout feeds the accumulator carry.
  - No other arithmetic sub-modules are used.

Verification
REQ-022 Small operands: a=3, b=5, start pulse -> done after N+1 cycles, product=15, busy high for exactly N cycles.
REQ-023 Maximum operands: a=b=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001, which exercises the adder carry every step.
REQ-024 Zero operand: a=0, b=32'h12345678 -> product=0. Then a=1, b=32'h80000000 -> product=64'h0000000080000000.
REQ-025 start held high during RUN while a and b change -> result equals the first captured operands, and exactly one done pulse occurs.
REQ-026 rst_n pulsed low at cycle 10 of a RUN -> busy=0, product=0, no done pulse. A following a=7, b=9 -> 63.
REQ-027 Back-to-back: start=1 in the DONE cycle with a=2, b=4 -> first result held that cycle, then second done with product=8.

Source files
------------

// File: rtl/seq_mult_nbit_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// State encoding and default operand width live here.
package seq_mult_nbit_pkg;

  localparam int DEF_N = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/seq_mult_nbit_adder.sv
// Ripple-carry N-bit adder used for the partial-product accumulate.
// Port names follow the classic A/B/Cin/Sum/Cout form.
module full_adder_nbit #(
  parameter int N = 32
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  logic [N:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign Sum[i] = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i])
                  | (A[i] & c[i])
                  | (B[i] & c[i]);
  end

  assign Cout = c[N];

endmodule

// File: rtl/seq_mult_nbit.sv
// Unsigned N x N sequential multiplier, one multiplier bit per cycle.
// Accumulator {hi, lo} doubles as the product register.
module seq_mult_nbit
  import seq_mult_nbit_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = cnt_w(N);

  state_t        state;
  logic [N-1:0]  mcand;
  logic [N-1:0]  hi;
  logic [N-1:0]  lo;
  logic [CW-1:0] cnt;

  logic [N-1:0]  sum;
  logic          cout;
  logic [N-1:0]  raw;
  logic          carry;

  full_adder_nbit #(.N(N)) u_add (
    .A    (hi),
    .B    (mcand),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (cout)
  );

  always_comb begin
    raw   = hi;
    carry = 1'b0;
    if (lo[0]) begin
      raw   = sum;
      carry = cout;
    end
  end

  assign product = {hi, lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            lo    <= b;
            hi    <= '0;
            cnt   <= CW'(N);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          // Shift {carry, raw, lo} right by one.
          hi  <= {carry, raw[N-1:1]};
          lo  <= {raw[0], lo[N-1:1]};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_nbit.sv
// Directed bench for seq_mult_nbit at N=32.
// Vector table plus hand-written multi-cycle sequences.
module tb_seq_mult_nbit;

  localparam int N = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          busy;
  logic          done;
  logic [2*N-1:0] product;

  int checks = 0;
  int errors = 0;

  seq_mult_nbit #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge.
  task automatic wait_done(output int cyc, output int bc);
    cyc = 1;
    bc  = 0;
    while (!done && cyc < 200) begin
      if (busy) bc++;
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc, bc, pulses;
  logic [63:0] cap;

  initial begin
    vecs[0] = '{"small",   32'd3,        32'd5,        64'd15};
    vecs[1] = '{"max",     32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[2] = '{"zero_a",  32'd0,        32'h12345678, 64'd0};
    vecs[3] = '{"msb_b",   32'd1,        32'h80000000, 64'h0000000080000000};
    vecs[4] = '{"seven9",  32'd7,        32'd9,        64'd63};
    vecs[5] = '{"max_one", 32'hFFFFFFFF, 32'd1,        64'h00000000FFFFFFFF};
    vecs[6] = '{"pow16",   32'h00010000, 32'h00010000, 64'h0000000100000000};
    vecs[7] = '{"dead2",   32'hDEADBEEF, 32'd2,        64'h00000001BD5B7DDE};
    vecs[8] = '{"shift4",  32'h12345678, 32'h10,       64'h0000000123456780};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #22;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done(cyc, bc);
      check({vecs[i].name, "_lat"}, 64'(cyc), 64'(N + 1));
      check({vecs[i].name, "_busy"}, 64'(bc), 64'(N));
      check({vecs[i].name, "_prod"}, product, vecs[i].p);
      @(negedge clk);
      check({vecs[i].name, "_done1"}, 64'(done), 64'd0);
      check({vecs[i].name, "_hold"}, product, vecs[i].p);
    end

    // start held high while operands churn during RUN
    @(negedge clk);
    a = 32'd10;
    b = 32'd11;
    start = 1'b1;
    pulses = 0;
    cap = '0;
    for (int j = 1; j <= N + 8; j++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        cap = product;
      end
      if (j < N - 1) begin
        a = $urandom;
        b = $urandom;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("hold_start_pulses", 64'(pulses), 64'd1);
    check("hold_start_prod", cap, 64'd110);

    // reset at cycle 10 of a RUN aborts it
    issue(32'd3, 32'd5);
    repeat (9) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_prod", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a = 32'd7;
    b = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_edge_accept", 64'(busy), 64'd1);
    wait_done(cyc, bc);
    check("post_rst_lat", 64'(cyc), 64'(N + 1));
    check("post_rst_prod", product, 64'd63);

    // back-to-back start in the DONE cycle
    issue(32'd6, 32'd7);
    wait_done(cyc, bc);
    check("b2b_first_lat", 64'(cyc), 64'(N + 1));
    check("b2b_first_prod", product, 64'd42);
    a = 32'd2;
    b = 32'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_done_low", 64'(done), 64'd0);
    wait_done(cyc, bc);
    check("b2b_second_lat", 64'(cyc), 64'(N + 1));
    check("b2b_second_busy", 64'(bc), 64'(N));
    check("b2b_second_prod", product, 64'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
